pso_best_tracker: RTL
=====================

# pso_best_tracker

Fitness/best-position tracker for the PSO MPPT loop. Consumes each particle's updated position together with the PV power measured at that position, and maintains per-particle personal best (P) and swarm global best (G). P and G feed the next velocity/position update for the addressed particle. Also counts completed swarm sweeps so the controller can bound the iteration count.

## Interface
- N_PART, 8: number of particles; table depth.
- AW, 3: particle address width; N_PART ≤ 2^AW.
- XW, 16: position width (unsigned duty/voltage code).
- PW, 32: measured power width (unsigned).
- MAX_ITER, 60: sweeps per run before `iter_done`.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous pulse; starts a table clear (new MPPT search).
- in_valid  in  1  sample present.
- in_ready  out  1  tracker can accept a sample this cycle.
- in_addr  in  AW  particle index of sample.
- in_x  in  XW  particle position.
- in_power  in  PW  power measured at in_x.
- out_valid  out  1  one-cycle strobe: out_* valid.
- out_addr  out  AW  particle index of result.
- out_p  out  XW  personal-best position of out_addr after update.
- out_g  out  XW  global-best position after update.
- g_power  out  PW  global-best power (continuously valid).
- g_valid  out  1  at least one sample absorbed since last clear/reset.
- iter  out  6  completed sweeps, 0..MAX_ITER-1.
- iter_done  out  1  one-cycle strobe when the sweep counter wraps.

## Operation
- State: per-entry pbest_x[XW], pbest_pw[PW], pvalid; global gx[XW], gpw[PW], g_valid; sweep counter iter; clear index.
- FSM states: RUN, CLEAR.
- RUN: in_ready = 1 unless clear = 1 that cycle (clear has priority; a sample presented with clear is not accepted).
- RUN: clear = 1 → CLEAR, clear index ← 0.
- CLEAR: one entry per cycle: pvalid[idx] ← 0, pbest_pw[idx] ← 0, pbest_x[idx] ← 0. On entry also g_valid ← 0, gpw ← 0, gx ← 0, iter ← 0. After idx = N_PART-1 → RUN. Duration exactly N_PART cycles; in_ready = 0 throughout. clear re-asserted during CLEAR restarts idx at 0.
- Accept = in_valid & in_ready. in_addr ≥ N_PART: sample accepted, table untouched, out_valid still pulses with out_p = 0, out_g = current gx.
- Personal update: if !pvalid[a] or in_power > pbest_pw[a] (strict, unsigned): pbest ← (in_x, in_power), pvalid ← 1. Equal power keeps old entry.
- Global update uses the post-personal-update candidate: if !g_valid or in_power > gpw (strict): gx ← in_x, gpw ← in_power, g_valid ← 1.
- Back-to-back samples to the same address see the previous sample's update (read-modify-write completes in the accept cycle; no hazard).
- Sweep: accepting in_addr = N_PART-1 increments iter; at MAX_ITER-1 it wraps to 0 and pulses iter_done.

## Timing
- Reset (async): state RUN, all table entries and pvalid cleared, gx = 0, gpw = 0, g_valid = 0, iter = 0; outputs: in_ready = 1 from first clock after reset release, out_valid = 0, out_addr = 0, out_p = 0, out_g = 0, g_power = 0, iter_done = 0.
- Latency 1: sample accepted at edge k → out_valid = 1 during cycle after edge k, for exactly one cycle; out_* hold until next result.
- Throughput: one sample per cycle in RUN; no output backpressure.
- g_power/g_valid/iter update at the same edge as the table write.
- clear in the cycle after an accepted sample: that sample's out_valid still fires; clear starts the following edge.
- Reset mid-CLEAR aborts it; post-reset state as above.

## Test plan
- Reset then samples addr 0..7, x = 100+i, power = 1000·(i+1) → each out_p = 100+i; out_g tracks latest; final gx = 107, g_power = 8000.
- addr 3 x = 500 p = 9000, then addr 3 x = 600 p = 9000 (tie), then x = 700 p = 8999 → out_p stays 500 all three; out_g = 500.
- Back-to-back addr 2 p = 10, 20, 15 on consecutive cycles → out_p = x of p 20 on third result; no stall, three strobes.
- 60 sweeps of addr 0..7 → iter counts 0..59, iter_done pulses once after 480th accept, iter = 0.
- clear while in_valid = 1 → sample not accepted, in_ready = 0 for 8 cycles, g_valid = 0, first post-clear sample becomes both P and G even with power 0.
- in_addr = 7 with N_PART = 6 → out_valid pulses, out_p = 0, table and G unchanged.

Source files
------------

// File: rtl/pso_best_tracker.sv
// PSO best tracker: per-particle personal best, swarm global best
// and sweep counter for the MPPT search loop.
module pso_best_tracker #(
  parameter int N_PART   = 8,
  parameter int AW       = 3,
  parameter int XW       = 16,
  parameter int PW       = 32,
  parameter int MAX_ITER = 60
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_addr,
  input  logic [XW-1:0] in_x,
  input  logic [PW-1:0] in_power,
  output logic          out_valid,
  output logic [AW-1:0] out_addr,
  output logic [XW-1:0] out_p,
  output logic [XW-1:0] out_g,
  output logic [PW-1:0] g_power,
  output logic          g_valid,
  output logic [5:0]    iter,
  output logic          iter_done
);

  localparam logic [0:0] S_RUN = 1'b0;
  localparam logic [0:0] S_CLR = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;

  logic [XW-1:0]     px_q  [N_PART];
  logic [PW-1:0]     ppw_q [N_PART];
  logic [N_PART-1:0] pv_q;

  logic [XW-1:0] gx_q;
  logic [PW-1:0] gpw_q;
  logic          gv_q;
  logic [5:0]    iter_q;

  logic          ov_q, done_q;
  logic [AW-1:0] oa_q;
  logic [XW-1:0] op_q, og_q;

  logic          acc, in_rng, last;
  logic          p_upd, g_upd;
  logic [XW-1:0] cur_x, new_p;
  logic [PW-1:0] cur_pw;
  logic          cur_v;

  assign in_ready = (state_q == S_RUN) & ~clear;
  assign acc      = in_valid & in_ready;
  assign in_rng   = {1'b0, in_addr} < (AW+1)'(N_PART);
  assign last     = in_addr == AW'(N_PART-1);

  // Out-of-range addresses read as an empty entry and never write.
  assign cur_x  = in_rng ? px_q[in_addr]  : '0;
  assign cur_pw = in_rng ? ppw_q[in_addr] : '0;
  assign cur_v  = in_rng & pv_q[in_addr];

  assign p_upd = in_rng & (~cur_v | (in_power > cur_pw));
  assign g_upd = in_rng & (~gv_q | (in_power > gpw_q));
  assign new_p = p_upd ? in_x : cur_x;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_RUN: begin
        if (clear) begin
          state_d = S_CLR;
          idx_d   = '0;
        end
      end
      S_CLR: begin
        if (clear) begin
          idx_d = '0;
        end else if (idx_q == AW'(N_PART-1)) begin
          state_d = S_RUN;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RUN;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_PART; i++) begin
        px_q[i]  <= '0;
        ppw_q[i] <= '0;
      end
      pv_q <= '0;
    end else if (state_q == S_CLR) begin
      px_q[idx_q]  <= '0;
      ppw_q[idx_q] <= '0;
      pv_q[idx_q]  <= 1'b0;
    end else if (acc & p_upd) begin
      px_q[in_addr]  <= in_x;
      ppw_q[in_addr] <= in_power;
      pv_q[in_addr]  <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gx_q   <= '0;
      gpw_q  <= '0;
      gv_q   <= 1'b0;
      iter_q <= '0;
      done_q <= 1'b0;
      ov_q   <= 1'b0;
      oa_q   <= '0;
      op_q   <= '0;
      og_q   <= '0;
    end else begin
      done_q <= 1'b0;
      ov_q   <= acc;
      if (clear) begin
        gx_q   <= '0;
        gpw_q  <= '0;
        gv_q   <= 1'b0;
        iter_q <= '0;
      end else if (acc) begin
        if (g_upd) begin
          gx_q  <= in_x;
          gpw_q <= in_power;
          gv_q  <= 1'b1;
        end
        if (last) begin
          if (iter_q == 6'(MAX_ITER-1)) begin
            iter_q <= '0;
            done_q <= 1'b1;
          end else begin
            iter_q <= iter_q + 6'd1;
          end
        end
      end
      if (acc) begin
        oa_q <= in_addr;
        op_q <= in_rng ? new_p : '0;
        og_q <= g_upd ? in_x : gx_q;
      end
    end
  end

  assign out_valid = ov_q;
  assign out_addr  = oa_q;
  assign out_p     = op_q;
  assign out_g     = og_q;
  assign g_power   = gpw_q;
  assign g_valid   = gv_q;
  assign iter      = iter_q;
  assign iter_done = done_q;

endmodule
